// File: rtl/alu_exec_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the ALU execution unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1110;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_JR  = 4'b1100;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_JR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/response handshake bundle between operand fetch, alu_exec and write-back.
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_shift_step.sv
// Combinational one-bit shift of the operand, direction and fill selected by op.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU: single-cycle add/sub/logic/jr, iterative one-bit-per-cycle shifts,
// valid/ready handshakes on request and result sides.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic     clk,
  input logic     rst,
  alu_exec_if.slave bus
);

  logic [1:0]       state;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             ill_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] comb_res;
  logic             comb_ovf;
  logic [WIDTH-1:0] step_out;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    comb_res = '0;
    comb_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        comb_res = sum;
        comb_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        comb_res = diff;
        comb_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:                 comb_res = bus.a & bus.b;
      OP_OR:                  comb_res = bus.a | bus.b;
      OP_XOR:                 comb_res = bus.a ^ bus.b;
      OP_JR:                  comb_res = bus.a;
      OP_SLL, OP_SRL, OP_SRA: comb_res = bus.b;
      default:                comb_res = '0;
    endcase
  end

  // The result register doubles as the shift register; out_valid is low while it shifts.
  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .op   (op_q),
    .din  (result_q),
    .dout (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q     <= bus.op;
            result_q <= comb_res;
            ovf_q    <= comb_ovf;
            ill_q    <= !is_legal(bus.op);
            if (is_shift(bus.op) && (bus.shamt != '0)) begin
              cnt   <= bus.shamt;
              state <= S_SHIFT;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          result_q <= step_out;
          cnt      <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with hand-computed expected results and latencies.
module tb_alu_exec;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_exec_if #(.WIDTH(32), .SHW(5)) bus ();

  alu_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble operands after accept, measure latency, check outputs, release.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_ill, input int exp_lat);
    int lat;
    chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.shamt = sh;
    tick();
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.shamt = 5'($urandom);
    bus.op = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({name, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({name, ".result"}, bus.result, exp_res);
    chk({name, ".zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
    chk({name, ".overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({name, ".illegal"}, 32'(bus.illegal), 32'(exp_ill));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, ".back_idle"}, 32'(bus.in_ready), 32'd1);
    chk({name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, ".result"}, bus.result, 32'd0);
    chk({name, ".zero"}, 32'(bus.zero), 32'd1);
    chk({name, ".overflow"}, 32'(bus.overflow), 32'd0);
    chk({name, ".illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.shamt = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1);
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1);
    run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 1);
    run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    run_op("and", OP_AND, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd3, 32'hF0F0_0000, 1'b0, 1'b0, 1);
    run_op("or", OP_OR, 32'hF0F0_F0F0, 32'h0F00_000F, 5'd0, 32'hFFF0_F0FF, 1'b0, 1'b0, 1);
    run_op("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, 32'h0F0F_F0F0, 1'b0, 1'b0, 1);
    run_op("sra31", OP_SRA, 32'h1234_5678, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    run_op("srl31", OP_SRL, 32'h1234_5678, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 32);
    run_op("sll0", OP_SLL, 32'h0, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1'b0, 1);
    run_op("sll4", OP_SLL, 32'h0, 32'h8000_0003, 5'd4, 32'h0000_0030, 1'b0, 1'b0, 5);
    run_op("sra4pos", OP_SRA, 32'h0, 32'h7000_0000, 5'd4, 32'h0700_0000, 1'b0, 1'b0, 5);
    run_op("srl1", OP_SRL, 32'h0, 32'h8000_0001, 5'd1, 32'h4000_0000, 1'b0, 1'b0, 2);
    run_op("illegal", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 1);

    // Backpressure: hold the result while a second request is presented.
    bus.in_valid = 1'b1;
    bus.op = OP_AND;
    bus.a = 32'h0000_FF00;
    bus.b = 32'h0000_0F0F;
    tick();
    bus.op = OP_ADD;
    bus.a = 32'h1111_1111;
    bus.b = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      chk("bp.result", bus.result, 32'h0000_0F00);
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp.release_idle", 32'(bus.in_ready), 32'd1);
    chk("bp.no_second", 32'(bus.out_valid), 32'd0);
    tick();
    chk("bp.still_idle", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a 20-bit shift, at the seventh cycle after accept.
    bus.in_valid = 1'b1;
    bus.op = OP_SLL;
    bus.b = 32'h0000_0001;
    bus.shamt = 5'd20;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid.in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    run_op("jr", OP_JR, 32'h0040_0020, 32'hFFFF_FFFF, 5'd7, 32'h0040_0020, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
